// File: rtl/nv_nvdla_csb_pkg.sv
// ----------------------------------------------------------------------------
// nv_nvdla_csb_pkg
//   Shared definitions for the CSB request initiator:
//   - request packet (63 bit) and response packet (34 bit) field offsets/widths
//   - response type encodings
//   - initiator FSM state enum
//   - pack_req(): builds a request packet from its fields
// No ports (package).
// ----------------------------------------------------------------------------
package nv_nvdla_csb_pkg;

    localparam int REQ_PD_W  = 63;
    localparam int RESP_PD_W = 34;
    localparam int ADDR_W    = 22;
    localparam int DATA_W    = 32;
    localparam int WRBE_W    = 4;
    localparam int LEVEL_W   = 2;

    // Request packet layout
    localparam int REQ_ADDR_LSB    = 0;
    localparam int REQ_WDAT_LSB    = 22;
    localparam int REQ_WRITE_BIT   = 54;
    localparam int REQ_NPOSTED_BIT = 55;
    localparam int REQ_SRCPRIV_BIT = 56;
    localparam int REQ_WRBE_LSB    = 57;
    localparam int REQ_LEVEL_LSB   = 61;

    // Response packet layout
    localparam int RESP_RDAT_LSB  = 0;
    localparam int RESP_ERROR_BIT = 32;
    localparam int RESP_TYPE_BIT  = 33;

    // Response type encodings
    localparam logic RESP_TYPE_RDAT = 1'b0;
    localparam logic RESP_TYPE_WACK = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_CPL  = 2'd3
    } csb_state_e;

    function automatic logic [REQ_PD_W-1:0] pack_req(
        input logic [LEVEL_W-1:0] level,
        input logic [WRBE_W-1:0]  wrbe,
        input logic               srcpriv,
        input logic               nposted,
        input logic               write,
        input logic [DATA_W-1:0]  wdat,
        input logic [ADDR_W-1:0]  addr
    );
        logic [REQ_PD_W-1:0] pd;
        pd = '0;
        pd[REQ_LEVEL_LSB +: LEVEL_W] = level;
        pd[REQ_WRBE_LSB +: WRBE_W]   = wrbe;
        pd[REQ_SRCPRIV_BIT]          = srcpriv;
        pd[REQ_NPOSTED_BIT]          = nposted;
        pd[REQ_WRITE_BIT]            = write;
        pd[REQ_WDAT_LSB +: DATA_W]   = wdat;
        pd[REQ_ADDR_LSB +: ADDR_W]   = addr;
        return pd;
    endfunction

endpackage

// File: rtl/nv_nvdla_csb_initiator_if.sv
// ----------------------------------------------------------------------------
// nv_nvdla_csb_initiator_if
//   Bundles the command, CSB request, CSB response and completion channels of
//   the CSB initiator.
//   modport master : initiator view (drives cmd_ready, req_*, cpl_*, stray_resp)
//   modport slave  : environment view (drives cmd_*, req_prdy, resp_*, cpl_ready)
//
//   Handshakes: a transfer on cmd (cmd_valid & cmd_ready), req
//   (req_pvld & req_prdy) and cpl (cpl_valid & cpl_ready) happens on the rising
//   clock edge where both are high; once a valid is raised it and its payload
//   stay stable until the transfer.  resp_valid is a one-cycle strobe with no
//   back-pressure.
// ----------------------------------------------------------------------------
interface nv_nvdla_csb_initiator_if;
    import nv_nvdla_csb_pkg::*;

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [ADDR_W-1:0]    cmd_addr;
    logic [DATA_W-1:0]    cmd_wdat;
    logic [WRBE_W-1:0]    cmd_wrbe;
    logic                 cmd_write;
    logic                 cmd_nposted;

    logic                 req_pvld;
    logic                 req_prdy;
    logic [REQ_PD_W-1:0]  req_pd;

    logic                 resp_valid;
    logic [RESP_PD_W-1:0] resp_pd;

    logic                 cpl_valid;
    logic                 cpl_ready;
    logic [DATA_W-1:0]    cpl_rdat;
    logic                 cpl_error;
    logic                 cpl_timeout;
    logic                 stray_resp;

    modport master (
        input  cmd_valid, cmd_addr, cmd_wdat, cmd_wrbe, cmd_write, cmd_nposted,
        output cmd_ready,
        output req_pvld, req_pd,
        input  req_prdy,
        input  resp_valid, resp_pd,
        output cpl_valid, cpl_rdat, cpl_error, cpl_timeout, stray_resp,
        input  cpl_ready
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_wdat, cmd_wrbe, cmd_write, cmd_nposted,
        input  cmd_ready,
        input  req_pvld, req_pd,
        output req_prdy,
        output resp_valid, resp_pd,
        input  cpl_valid, cpl_rdat, cpl_error, cpl_timeout, stray_resp,
        output cpl_ready
    );

endinterface

// File: rtl/nv_nvdla_csb_timeout_cnt.sv
// ----------------------------------------------------------------------------
// nv_nvdla_csb_timeout_cnt
//   Response-wait counter.  Cleared by clr, advances by one per cycle with en,
//   saturates at TIMEOUT_CYCLES-1.  expire is high while the count sits at
//   TIMEOUT_CYCLES-1, i.e. during the TIMEOUT_CYCLES-th waiting cycle.
// Ports:
//   nvdla_core_clk  in   clock
//   nvdla_core_rst  in   asynchronous active-high reset
//   clr             in   restart counting from 0
//   en              in   count this cycle
//   expire          out  count == TIMEOUT_CYCLES-1
// ----------------------------------------------------------------------------
module nv_nvdla_csb_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic nvdla_core_clk,
    input  logic nvdla_core_rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int              CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != LAST)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expire = (count == LAST);

endmodule

// File: rtl/nv_nvdla_csb_initiator.sv
// ----------------------------------------------------------------------------
// nv_nvdla_csb_initiator
//   CSB master: accepts one register command at a time, issues it as a 63-bit
//   CSB request, waits for the 34-bit response (unless posted write) and
//   presents a completion.  Responses arriving while not waiting are dropped
//   and flagged on stray_resp the following cycle.
//   Optional response timeout: compile with NVDLA_CSB_TIMEOUT_EN defined.
// Parameters:
//   REQ_LEVEL       value of req_pd[62:61]
//   REQ_SRCPRIV     value of req_pd[56]
//   TIMEOUT_CYCLES  WAIT cycles before timeout completion (>= 2)
// Ports:
//   nvdla_core_clk  in   core clock
//   nvdla_core_rst  in   asynchronous active-high reset
//   bus             master modport: cmd / req / resp / cpl channels, stray_resp
//   dbg_state       out  current FSM state
// ----------------------------------------------------------------------------
module nv_nvdla_csb_initiator
    import nv_nvdla_csb_pkg::*;
#(
    parameter logic [1:0] REQ_LEVEL      = 2'b00,
    parameter logic       REQ_SRCPRIV    = 1'b0,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic                            nvdla_core_clk,
    input  logic                            nvdla_core_rst,
    nv_nvdla_csb_initiator_if.master        bus,
    output csb_state_e                      dbg_state
);

    csb_state_e          state;
    csb_state_e          next_state;

    logic [REQ_PD_W-1:0] req_pd_q;
    logic [DATA_W-1:0]   cpl_rdat_q;
    logic                cpl_error_q;
    logic                cpl_timeout_q;
    logic                stray_q;

    logic                cmd_ready_int;
    logic                cmd_accept;
    logic                posted_done;
    logic                resp_take;
    logic                tmo_hit;

    logic                req_is_write;
    logic                req_posted;
    logic                type_mismatch;
    logic                resp_error;
    logic [DATA_W-1:0]   resp_rdat;

    // The outstanding request's kind is read back from the held packet.
    assign req_is_write = req_pd_q[REQ_WRITE_BIT];
    assign req_posted   = req_is_write && !req_pd_q[REQ_NPOSTED_BIT];

    assign type_mismatch = bus.resp_pd[RESP_TYPE_BIT] !=
                           (req_is_write ? RESP_TYPE_WACK : RESP_TYPE_RDAT);
    assign resp_error    = bus.resp_pd[RESP_ERROR_BIT] || type_mismatch;
    // Write acks carry no data; a mismatched response's data is not trusted.
    assign resp_rdat     = (req_is_write || type_mismatch) ? '0
                                                           : bus.resp_pd[RESP_RDAT_LSB +: DATA_W];

`ifdef NVDLA_CSB_TIMEOUT_EN
    logic wait_enter;
    logic tmo_expire;

    assign wait_enter = (state == ST_REQ) && bus.req_prdy && !req_posted;

    nv_nvdla_csb_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .nvdla_core_clk (nvdla_core_clk),
        .nvdla_core_rst (nvdla_core_rst),
        .clr            (wait_enter),
        .en             ((state == ST_WAIT) && !bus.resp_valid),
        .expire         (tmo_expire)
    );

    // A response in the expiring cycle still wins.
    assign tmo_hit = (state == ST_WAIT) && !bus.resp_valid && tmo_expire;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES < 2);
    assign tmo_hit            = 1'b0;
`endif

    // cmd_ready is held low while reset is asserted even though the state
    // register already reads IDLE.
    assign cmd_ready_int = (state == ST_IDLE) && !nvdla_core_rst;

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        cmd_accept  = 1'b0;
        posted_done = 1'b0;
        resp_take   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.cmd_valid && cmd_ready_int) begin
                    cmd_accept = 1'b1;
                    next_state = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.req_prdy) begin
                    if (req_posted) begin
                        posted_done = 1'b1;
                        next_state  = ST_CPL;
                    end else begin
                        next_state  = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (bus.resp_valid) begin
                    resp_take  = 1'b1;
                    next_state = ST_CPL;
                end else if (tmo_hit) begin
                    next_state = ST_CPL;
                end
            end
            ST_CPL: begin
                if (bus.cpl_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            req_pd_q      <= '0;
            cpl_rdat_q    <= '0;
            cpl_error_q   <= 1'b0;
            cpl_timeout_q <= 1'b0;
            stray_q       <= 1'b0;
        end else begin
            stray_q <= bus.resp_valid && (state != ST_WAIT);

            if (cmd_accept) begin
                req_pd_q <= pack_req(REQ_LEVEL, bus.cmd_wrbe, REQ_SRCPRIV, bus.cmd_nposted,
                                     bus.cmd_write, bus.cmd_wdat, bus.cmd_addr);
            end

            if (posted_done) begin
                cpl_rdat_q    <= '0;
                cpl_error_q   <= 1'b0;
                cpl_timeout_q <= 1'b0;
            end else if (resp_take) begin
                cpl_rdat_q    <= resp_rdat;
                cpl_error_q   <= resp_error;
                cpl_timeout_q <= 1'b0;
            end else if (tmo_hit) begin
                cpl_rdat_q    <= '0;
                cpl_error_q   <= 1'b1;
                cpl_timeout_q <= 1'b1;
            end
        end
    end

    assign bus.cmd_ready   = cmd_ready_int;
    assign bus.req_pvld    = (state == ST_REQ);
    assign bus.req_pd      = req_pd_q;
    assign bus.cpl_valid   = (state == ST_CPL);
    assign bus.cpl_rdat    = cpl_rdat_q;
    assign bus.cpl_error   = cpl_error_q;
    assign bus.cpl_timeout = cpl_timeout_q;
    assign bus.stray_resp  = stray_q;
    assign dbg_state       = state;

endmodule

// File: tb/tb_nv_nvdla_csb_initiator.sv
module tb_nv_nvdla_csb_initiator;
    import nv_nvdla_csb_pkg::*;

    localparam int TO_CYC = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nv_nvdla_csb_initiator_if bus();
    csb_state_e dbg_state;

    nv_nvdla_csb_initiator #(
        .REQ_LEVEL      (2'b00),
        .REQ_SRCPRIV    (1'b0),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .bus            (bus),
        .dbg_state      (dbg_state)
    );

    int checks   = 0;
    int failures = 0;
    logic [33:0] exp_q[$];   // {timeout, error, rdat}

    typedef struct {
        logic        wr;
        logic        np;
        logic [21:0] addr;
        logic [31:0] wdat;
        logic [3:0]  be;
        int          pw;
        int          resp_at;
        logic        has_resp;
        logic        rtype;
        logic        rerr;
        logic [31:0] rrd;
        logic        stray;
        logic [33:0] exp_cpl;
        int          exp_lat;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [62:0] model_pd(input logic wr, input logic np, input logic [21:0] a,
                                              input logic [31:0] d, input logic [3:0] be);
        return {2'b00, be, 1'b0, np, wr, d, a};
    endfunction

    function automatic bit model_timed_out(input logic has_resp, input int resp_at);
`ifdef NVDLA_CSB_TIMEOUT_EN
        return (!has_resp) || (resp_at > TO_CYC);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [33:0] model_cpl(input logic wr, input logic np, input logic has_resp,
                                              input int resp_at, input logic rtype, input logic rerr,
                                              input logic [31:0] rrd);
        if (wr && !np) return {1'b0, 1'b0, 32'h0};
        if (model_timed_out(has_resp, resp_at)) return {1'b1, 1'b1, 32'h0};
        if (rtype != wr) return {1'b0, 1'b1, 32'h0};
        return {1'b0, rerr, (wr ? 32'h0 : rrd)};
    endfunction

    function automatic int model_lat(input logic wr, input logic np, input logic has_resp,
                                     input int pw, input int resp_at);
        if (wr && !np) return 2 + pw;
        if (model_timed_out(has_resp, resp_at)) return 2 + pw + TO_CYC;
        return 2 + pw + resp_at;
    endfunction

    // ---------------- driver / monitor ----------------
    // Cycle numbering: the command is accepted at the end of cycle N; the
    // negedge in cycle N+k has cyc == k.
    task automatic run_txn(input string tag, input vec_t v);
        logic [62:0] exp_pd;
        logic [33:0] exp_c;
        int          cyc;
        int          errs;
        bit          seen;

        exp_pd = model_pd(v.wr, v.np, v.addr, v.wdat, v.be);
        exp_c  = (exp_q.size() > 0) ? exp_q.pop_front() : 34'h0;

        @(negedge clk);
        check($sformatf("%s.cmd_ready", tag), bus.cmd_ready, 1);
        bus.cmd_valid   = 1'b1;
        bus.cmd_write   = v.wr;
        bus.cmd_nposted = v.np;
        bus.cmd_addr    = v.addr;
        bus.cmd_wdat    = v.wdat;
        bus.cmd_wrbe    = v.be;

        @(negedge clk);
        cyc = 1;
        bus.cmd_valid   = 1'b0;
        bus.cmd_addr    = 22'($urandom);
        bus.cmd_wdat    = $urandom;
        bus.cmd_wrbe    = 4'($urandom);
        bus.cmd_write   = 1'($urandom);
        bus.cmd_nposted = 1'($urandom);

        errs = 0;
        for (int i = 0; i <= v.pw; i++) begin
            if (i > 0) begin
                @(negedge clk);
                cyc++;
                if (bus.req_pvld !== 1'b1 || bus.req_pd !== exp_pd) errs++;
            end else begin
                check($sformatf("%s.req_pvld", tag), bus.req_pvld, 1);
                check($sformatf("%s.req_pd", tag), bus.req_pd, exp_pd);
            end
            if (i == v.pw) bus.req_prdy = 1'b1;
        end
        check($sformatf("%s.req_hold_errs", tag), errs, 0);

        seen = 1'b0;
        for (int k = 1; k <= 200 && !seen; k++) begin
            @(negedge clk);
            cyc++;
            bus.req_prdy   = 1'b0;
            bus.resp_valid = v.has_resp && (k == v.resp_at);
            if (bus.resp_valid) bus.resp_pd = {v.rtype, v.rerr, v.rrd};
            else                bus.resp_pd = {2'($urandom), $urandom};
            if (k == 1) check($sformatf("%s.req_drop", tag), bus.req_pvld, 0);
            if (bus.cpl_valid === 1'b1) seen = 1'b1;
        end

        if (!seen) begin
            check($sformatf("%s.cpl_budget", tag), 0, 1);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
        end else begin
            check($sformatf("%s.cpl_latency", tag), cyc, v.exp_lat);
            check($sformatf("%s.cpl_rdat", tag), bus.cpl_rdat, exp_c[31:0]);
            check($sformatf("%s.cpl_error", tag), bus.cpl_error, exp_c[32]);
            check($sformatf("%s.cpl_timeout", tag), bus.cpl_timeout, exp_c[33]);
            check($sformatf("%s.no_stray", tag), bus.stray_resp, 0);

            if (v.stray) begin
                bus.resp_valid = 1'b1;
                bus.resp_pd    = {2'($urandom), $urandom};
                @(negedge clk);
                bus.resp_valid = 1'b0;
                check($sformatf("%s.stray_pulse", tag), bus.stray_resp, 1);
                check($sformatf("%s.stray_cpl_valid", tag), bus.cpl_valid, 1);
                check($sformatf("%s.stray_cpl_rdat", tag), bus.cpl_rdat, exp_c[31:0]);
                check($sformatf("%s.stray_cpl_error", tag), bus.cpl_error, exp_c[32]);
                @(negedge clk);
                check($sformatf("%s.stray_end", tag), bus.stray_resp, 0);
            end

            errs = 0;
            for (int h = 0; h < int'($urandom_range(0, 2)); h++) begin
                @(negedge clk);
                if (bus.cpl_valid !== 1'b1 || {bus.cpl_timeout, bus.cpl_error, bus.cpl_rdat} !== exp_c)
                    errs++;
            end
            check($sformatf("%s.cpl_hold_errs", tag), errs, 0);

            bus.cpl_ready = 1'b1;
            @(negedge clk);
            bus.cpl_ready = 1'b0;
            check($sformatf("%s.b2b_cmd_ready", tag), bus.cmd_ready, 1);
            check($sformatf("%s.cpl_drop", tag), bus.cpl_valid, 0);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic np, input logic [21:0] a, input logic [31:0] d,
                                input logic [3:0] be, input int pw, input int resp_at, input logic has_resp,
                                input logic rtype, input logic rerr, input logic [31:0] rrd, input logic stray,
                                input logic [33:0] exp_cpl, input int exp_lat);
        vec_t v;
        v.wr = wr; v.np = np; v.addr = a; v.wdat = d; v.be = be; v.pw = pw; v.resp_at = resp_at;
        v.has_resp = has_resp; v.rtype = rtype; v.rerr = rerr; v.rrd = rrd; v.stray = stray;
        v.exp_cpl = exp_cpl; v.exp_lat = exp_lat;
        return v;
    endfunction

    initial begin
        vec_t v;

        bus.cmd_valid = 1'b0; bus.cmd_addr = '0; bus.cmd_wdat = '0; bus.cmd_wrbe = '0;
        bus.cmd_write = 1'b0; bus.cmd_nposted = 1'b0; bus.req_prdy = 1'b0;
        bus.resp_valid = 1'b0; bus.resp_pd = '0; bus.cpl_ready = 1'b0;

        // ---- reset values ----
        repeat (3) @(negedge clk);
        check("rst.cmd_ready", bus.cmd_ready, 0);
        check("rst.req_pvld", bus.req_pvld, 0);
        check("rst.req_pd", bus.req_pd, 0);
        check("rst.cpl_valid", bus.cpl_valid, 0);
        check("rst.cpl_rdat", bus.cpl_rdat, 0);
        check("rst.cpl_error", bus.cpl_error, 0);
        check("rst.cpl_timeout", bus.cpl_timeout, 0);
        check("rst.stray_resp", bus.stray_resp, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst.cmd_ready", bus.cmd_ready, 1);
        check("post_rst.idle", dbg_state, ST_IDLE);

        // ---- table-driven vectors (expected values written out by hand) ----
        //         wr    np    addr        wdat          be    pw resp rsp   typ   err   rdat          stray exp{to,err,rdat}             lat
        vecs[0] = mk(1'b0, 1'b0, 22'h000010, 32'h0,        4'h0, 0, 2, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, {1'b0, 1'b0, 32'hDEADBEEF}, 4);
        vecs[1] = mk(1'b1, 1'b1, 22'h00002A, 32'h12345678, 4'hF, 3, 2, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, {1'b0, 1'b0, 32'h0},        7);
        vecs[2] = mk(1'b1, 1'b0, 22'h3FFFFF, 32'hA5A5A5A5, 4'h3, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, {1'b0, 1'b0, 32'h0},        2);
        vecs[3] = mk(1'b0, 1'b0, 22'h000100, 32'h0,        4'h0, 0, 2, 1'b1, 1'b1, 1'b0, 32'hCAFEF00D, 1'b0, {1'b0, 1'b1, 32'h0},        4);
        vecs[4] = mk(1'b0, 1'b0, 22'h001234, 32'h0,        4'h0, 1, 1, 1'b1, 1'b0, 1'b1, 32'h00000055, 1'b1, {1'b0, 1'b1, 32'h00000055}, 4);
        vecs[5] = mk(1'b1, 1'b1, 22'h0ABCDE, 32'h0F0F0F0F, 4'h5, 0, 3, 1'b1, 1'b0, 1'b0, 32'h00000077, 1'b0, {1'b0, 1'b1, 32'h0},        5);
        vecs[6] = mk(1'b1, 1'b1, 22'h200000, 32'hFFFFFFFF, 4'h8, 0, 2, 1'b1, 1'b1, 1'b1, 32'h0,        1'b0, {1'b0, 1'b1, 32'h0},        4);
        vecs[7] = mk(1'b1, 1'b0, 22'h155555, 32'h87654321, 4'hC, 2, 0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, {1'b0, 1'b0, 32'h0},        4);

        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(vecs[i].exp_cpl);
            run_txn($sformatf("vec%0d", i), vecs[i]);
        end

        // ---- response-wait corner cases ----
`ifdef NVDLA_CSB_TIMEOUT_EN
        // no response: timeout after TO_CYC WAIT cycles
        v = mk(1'b0, 1'b0, 22'h000040, 32'h0, 4'h0, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0,
               {1'b1, 1'b1, 32'h0}, 10);
        exp_q.push_back(v.exp_cpl);
        run_txn("tmo_read", v);
        // response on the last WAIT cycle wins
        v = mk(1'b0, 1'b0, 22'h000044, 32'h0, 4'h0, 0, 8, 1'b1, 1'b0, 1'b0, 32'h00001234, 1'b0,
               {1'b0, 1'b0, 32'h00001234}, 10);
        exp_q.push_back(v.exp_cpl);
        run_txn("tmo_edge_resp", v);
        // non-posted write, back-pressured, never acknowledged
        v = mk(1'b1, 1'b1, 22'h000048, 32'h11112222, 4'hF, 2, 0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1,
               {1'b1, 1'b1, 32'h0}, 12);
        exp_q.push_back(v.exp_cpl);
        run_txn("tmo_write", v);
`else
        // long-latency response: initiator keeps waiting, no timeout flag
        v = mk(1'b0, 1'b0, 22'h000040, 32'h0, 4'h0, 0, 40, 1'b1, 1'b0, 1'b0, 32'h600DF00D, 1'b0,
               {1'b0, 1'b0, 32'h600DF00D}, 42);
        exp_q.push_back(v.exp_cpl);
        run_txn("long_wait", v);
`endif

        // ---- randomized transactions against the model ----
        for (int n = 0; n < 30; n++) begin
            v.wr       = 1'($urandom);
            v.np       = 1'($urandom);
            v.addr     = 22'($urandom);
            v.wdat     = $urandom;
            v.be       = 4'($urandom);
            v.pw       = int'($urandom_range(0, 3));
            v.resp_at  = int'($urandom_range(1, 6));
            v.has_resp = !(v.wr && !v.np);
            v.rtype    = ($urandom_range(0, 4) == 0) ? !v.wr : v.wr;
            v.rerr     = ($urandom_range(0, 3) == 0);
            v.rrd      = $urandom;
            v.stray    = 1'($urandom);
            v.exp_cpl  = model_cpl(v.wr, v.np, v.has_resp, v.resp_at, v.rtype, v.rerr, v.rrd);
            v.exp_lat  = model_lat(v.wr, v.np, v.has_resp, v.pw, v.resp_at);
            exp_q.push_back(v.exp_cpl);
            run_txn($sformatf("rnd%0d", n), v);
        end

        // ---- reset while waiting for a response, then a late response ----
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_nposted = 1'b0;
        bus.cmd_addr = 22'h000100; bus.cmd_wdat = 32'h0; bus.cmd_wrbe = 4'h0;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.req_prdy  = 1'b1;
        @(negedge clk);
        bus.req_prdy  = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst.cmd_ready", bus.cmd_ready, 0);
        check("midrst.req_pvld", bus.req_pvld, 0);
        check("midrst.req_pd", bus.req_pd, 0);
        check("midrst.cpl_valid", bus.cpl_valid, 0);
        check("midrst.cpl_rdat", bus.cpl_rdat, 0);
        check("midrst.cpl_error", bus.cpl_error, 0);
        check("midrst.cpl_timeout", bus.cpl_timeout, 0);
        check("midrst.stray_resp", bus.stray_resp, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus.resp_valid = 1'b1;
        bus.resp_pd    = {1'b0, 1'b0, 32'h00000BAD};
        @(negedge clk);
        bus.resp_valid = 1'b0;
        check("late.stray_resp", bus.stray_resp, 1);
        check("late.cmd_ready", bus.cmd_ready, 1);
        check("late.cpl_valid", bus.cpl_valid, 0);
        check("late.req_pvld", bus.req_pvld, 0);
        @(negedge clk);
        check("late.stray_end", bus.stray_resp, 0);
        check("late.still_idle", bus.cmd_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
